// File: rtl/debug_unit.sv
// debug_unit -- serial-command debug controller for the MIPS pipeline.
//
// The unit takes single-byte ASCII commands from a UART receiver and
// answers them through a UART transmitter. It can single-step or free-run
// the pipeline, and it can dump the PC, the 32 GPRs or the first
// TAM_DATA_MEMORY data-memory words. Every word goes out as
// NB/NB_BYTE bytes, most significant byte first.
//
// Ports
//   i_clk                         clock, rising edge
//   i_reset                       asynchronous reset, active low
//   i_rx_data / i_rx_valid        received command byte and its valid pulse
//   o_tx_data / o_tx_start        byte to send and its start pulse
//   i_tx_done                     transmitter finished the current byte
//   o_step                        pipeline advance enable
//   i_mips_halt                   pipeline has retired a HALT (level)
//   i_mips_pc                     current PC
//   o_debug_mips_register_number  register select into the pipeline
//   i_mips_register_data          value of the selected register
//   o_debug_address               data-memory byte address into the pipeline
//   i_mips_data_memory            data-memory word at o_debug_address
//
// States
//   IDLE    | waiting for a command byte
//   STEP    | o_step high for this single cycle
//   RUN     | o_step high until HALT is seen or 'H' is received
//   SELECT  | drive register number / memory address for the next word
//   CAPTURE | latch the selected word, present its first byte
//   SEND    | o_tx_start pulse for the current byte
//   WAIT_TX | hold the byte until i_tx_done

module debug_unit #(
    parameter int NB              = 32,
    parameter int NB_BYTE         = 8,
    parameter int TAM_DATA_MEMORY = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_step,
    input  logic               i_mips_halt,
    input  logic [NB-1:0]      i_mips_pc,
    output logic [4:0]         o_debug_mips_register_number,
    input  logic [NB-1:0]      i_mips_register_data,
    output logic [NB-1:0]      o_debug_address,
    input  logic [NB-1:0]      i_mips_data_memory
);

    localparam int BYTES_PER_WORD = NB / NB_BYTE;
    localparam int N_REGS         = 32;
    localparam int IDX_MAX        = (TAM_DATA_MEMORY > N_REGS) ? TAM_DATA_MEMORY : N_REGS;
    localparam int IDX_W          = $clog2(IDX_MAX) + 1;
    localparam int BC_W           = $clog2(BYTES_PER_WORD) + 1;

    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'('h53);
    localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'('h43);
    localparam logic [NB_BYTE-1:0] CMD_HALT = NB_BYTE'('h48);
    localparam logic [NB_BYTE-1:0] CMD_PC   = NB_BYTE'('h50);
    localparam logic [NB_BYTE-1:0] CMD_REGS = NB_BYTE'('h52);
    localparam logic [NB_BYTE-1:0] CMD_MEM  = NB_BYTE'('h4D);

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        RUN,
        SELECT,
        CAPTURE,
        SEND,
        WAIT_TX
    } state_t;

    // Which pipeline source feeds the word being sent.
    typedef enum logic [1:0] {
        SRC_PC,
        SRC_REG,
        SRC_MEM
    } src_t;

    state_t            state;
    src_t              src;
    logic [NB-1:0]     word;
    logic [BC_W-1:0]   byte_cnt;
    logic [IDX_W-1:0]  word_idx;

    logic [NB-1:0]      cap_word;
    logic [BC_W-1:0]    next_cnt;
    logic [NB_BYTE-1:0] next_tx;
    logic               last_word;
    logic               last_byte;

    always_comb begin
        cap_word = i_mips_pc;
        case (src)
            SRC_REG: cap_word = i_mips_register_data;
            SRC_MEM: cap_word = i_mips_data_memory;
            default: cap_word = i_mips_pc;
        endcase
    end

    // Next byte of the latched word, counting from the MSB end. Only used
    // while byte_cnt is below the last byte, so the shift stays in range.
    always_comb begin
        next_cnt = byte_cnt + BC_W'(1);
        next_tx  = NB_BYTE'(word >> ((BYTES_PER_WORD - 1 - int'(next_cnt)) * NB_BYTE));
    end

    always_comb begin
        last_byte = (byte_cnt == BC_W'(BYTES_PER_WORD - 1));
        case (src)
            SRC_REG: last_word = (word_idx == IDX_W'(N_REGS - 1));
            SRC_MEM: last_word = (word_idx == IDX_W'(TAM_DATA_MEMORY - 1));
            default: last_word = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state                        <= IDLE;
            src                          <= SRC_PC;
            word                         <= '0;
            byte_cnt                     <= '0;
            word_idx                     <= '0;
            o_tx_data                    <= '0;
            o_tx_start                   <= 1'b0;
            o_step                       <= 1'b0;
            o_debug_mips_register_number <= '0;
            o_debug_address              <= '0;
        end else begin
            // o_tx_start is a one-cycle pulse; it is only raised on the
            // transitions into SEND below.
            o_tx_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_STEP: begin
                                src <= SRC_PC;
                                if (!i_mips_halt) begin
                                    o_step <= 1'b1;
                                    state  <= STEP;
                                end else begin
                                    state  <= CAPTURE;
                                end
                            end
                            CMD_CONT: begin
                                src <= SRC_PC;
                                if (!i_mips_halt) begin
                                    o_step <= 1'b1;
                                    state  <= RUN;
                                end else begin
                                    state  <= CAPTURE;
                                end
                            end
                            CMD_PC: begin
                                src   <= SRC_PC;
                                state <= CAPTURE;
                            end
                            CMD_REGS: begin
                                src      <= SRC_REG;
                                word_idx <= '0;
                                state    <= SELECT;
                            end
                            CMD_MEM: begin
                                src      <= SRC_MEM;
                                word_idx <= '0;
                                state    <= SELECT;
                            end
                            default: ;
                        endcase
                    end
                end

                STEP: begin
                    o_step <= 1'b0;
                    state  <= CAPTURE;
                end

                RUN: begin
                    if (i_mips_halt || (i_rx_valid && (i_rx_data == CMD_HALT))) begin
                        o_step <= 1'b0;
                        state  <= CAPTURE;
                    end
                end

                SELECT: begin
                    if (src == SRC_REG) begin
                        o_debug_mips_register_number <= word_idx[4:0];
                    end else begin
                        o_debug_address <= NB'(word_idx) << 2;
                    end
                    state <= CAPTURE;
                end

                // The pipeline read data is valid one cycle after the select,
                // so the word is latched here and kept for all its bytes.
                CAPTURE: begin
                    word       <= cap_word;
                    byte_cnt   <= '0;
                    o_tx_data  <= cap_word[NB-1 -: NB_BYTE];
                    o_tx_start <= 1'b1;
                    state      <= SEND;
                end

                SEND: begin
                    state <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (i_tx_done) begin
                        if (last_byte) begin
                            if (last_word) begin
                                state <= IDLE;
                            end else begin
                                word_idx <= word_idx + IDX_W'(1);
                                state    <= SELECT;
                            end
                        end else begin
                            byte_cnt   <= next_cnt;
                            o_tx_data  <= next_tx;
                            o_tx_start <= 1'b1;
                            state      <= SEND;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
module tb_debug_unit;

    localparam int NB      = 32;
    localparam int NB_BYTE = 8;
    localparam int TAM     = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NB_BYTE-1:0] rx_data;
    logic               rx_valid;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_start;
    logic               tx_done;
    logic               step;
    logic               halt;
    logic [NB-1:0]      pc;
    logic [4:0]         reg_num;
    logic [NB-1:0]      reg_data;
    logic [NB-1:0]      dbg_addr;
    logic [NB-1:0]      mem_data;

    logic [NB-1:0]      mem_model [TAM];

    always #5 clk = ~clk;

    debug_unit #(.NB(NB), .NB_BYTE(NB_BYTE), .TAM_DATA_MEMORY(TAM)) dut (
        .i_clk                        (clk),
        .i_reset                      (rst),
        .i_rx_data                    (rx_data),
        .i_rx_valid                   (rx_valid),
        .o_tx_data                    (tx_data),
        .o_tx_start                   (tx_start),
        .i_tx_done                    (tx_done),
        .o_step                       (step),
        .i_mips_halt                  (halt),
        .i_mips_pc                    (pc),
        .o_debug_mips_register_number (reg_num),
        .i_mips_register_data         (reg_data),
        .o_debug_address              (dbg_addr),
        .i_mips_data_memory           (mem_data)
    );

    // Pipeline model: r[n] = n * 0x01010101 except r31 = 0x18; memory from an array.
    assign reg_data = (reg_num == 5'd31) ? 32'h0000_0018 : (32'(reg_num) * 32'h0101_0101);
    assign mem_data = (dbg_addr < 32'(TAM * 4)) ? mem_model[dbg_addr[5:2]] : '0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter model and observers.
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int         steps    = 0;
    int         pending  = 0;
    int         unstable = 0;
    logic [7:0] last_tx  = '0;

    always @(negedge clk) begin
        if (!rst) begin
            pending = 0;
            tx_done = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (pending > 0) begin
                if (tx_data !== last_tx) unstable++;
                pending--;
                if (pending == 0) tx_done = 1'b1;
            end
            if (tx_start) begin
                got_q.push_back(tx_data);
                last_tx = tx_data;
                pending = 5;
            end
            if (step) steps++;
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(w >> (24 - 8 * i)));
    endtask

    task automatic send_byte(input logic [7:0] c);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = c;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        steps = 0;
    endtask

    task automatic finish_cmd(input string tag, input int exp_steps);
        for (int i = 0; i < 4000 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_steps"}, steps, exp_steps);
        clear_obs();
    endtask

    task automatic run_p(input string tag);
        clear_obs();
        push_word(pc);
        send_byte(8'h50);
        repeat (4) @(negedge clk);
        pc = $urandom;
        finish_cmd(tag, 0);
    endtask

    task automatic run_s(input string tag, input bit h);
        clear_obs();
        halt = h;
        push_word(pc);
        send_byte(8'h53);
        repeat (4) @(negedge clk);
        pc = $urandom;
        finish_cmd(tag, h ? 0 : 1);
        halt = 1'b0;
    endtask

    // 'C' run of n step cycles, ended by HALT or by 'H'; a stray 'S' is
    // injected mid-run when the run is long enough.
    task automatic run_c(input string tag, input int n, input bit use_h, input bit halt0);
        clear_obs();
        push_word(pc);
        if (halt0) begin
            halt = 1'b1;
            send_byte(8'h43);
        end else begin
            send_byte(8'h43);
            for (int i = 1; i <= n; i++) begin
                if (i > 1) @(negedge clk);
                if (i == n) begin
                    if (use_h) begin
                        rx_valid = 1'b1;
                        rx_data  = 8'h48;
                    end else begin
                        rx_valid = 1'b0;
                        halt     = 1'b1;
                    end
                end else if (i == 2) begin
                    rx_valid = 1'b1;
                    rx_data  = 8'h53;
                end else begin
                    rx_valid = 1'b0;
                end
            end
            @(negedge clk);
            rx_valid = 1'b0;
        end
        finish_cmd(tag, halt0 ? 0 : n);
        halt = 1'b0;
    endtask

    task automatic run_m(input string tag);
        clear_obs();
        for (int k = 0; k < TAM; k++) begin
            mem_model[k] = $urandom;
            push_word(mem_model[k]);
        end
        send_byte(8'h4D);
        finish_cmd(tag, 0);
        check({tag, "_addr_end"}, dbg_addr, 32'(4 * (TAM - 1)));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_step"}, step, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_reg_num"}, reg_num, 0);
        check({tag, "_addr"}, dbg_addr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int sel;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        halt     = 1'b0;
        pc       = '0;
        for (int k = 0; k < TAM; k++) mem_model[k] = $urandom;

        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs_zero("post_reset");
        check("post_reset_nbytes", got_q.size(), 0);

        pc = 32'h0000_000C;
        run_p("P_0C");

        clear_obs();
        send_byte(8'h58);
        send_byte(8'h48);
        finish_cmd("idle_ignore", 0);

        pc = 32'h1234_5678;
        run_s("S_nohalt", 1'b0);
        run_s("S_halt", 1'b1);

        clear_obs();
        for (int n = 0; n < 32; n++) push_word((n == 31) ? 32'h18 : 32'(n) * 32'h0101_0101);
        send_byte(8'h52);
        finish_cmd("R", 0);
        check("R_reg_num_end", reg_num, 31);

        run_m("M");

        run_c("C_halt10", 10, 1'b0, 1'b0);
        run_c("C_h6", 6, 1'b1, 1'b0);
        run_c("C_prehalt", 5, 1'b0, 1'b1);

        // Command bytes arriving while a response is in flight, including one
        // coinciding with i_tx_done, must be dropped.
        clear_obs();
        push_word(pc);
        send_byte(8'h50);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (tx_done) begin
                rx_valid = 1'b1;
                rx_data  = 8'h50;
                break;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        send_byte(8'h52);
        finish_cmd("busy_ignore", 0);
        check("tx_data_stable", unstable, 0);

        // Reset in the middle of a memory dump.
        clear_obs();
        for (int k = 0; k < TAM; k++) begin
            mem_model[k] = $urandom;
            push_word(mem_model[k]);
        end
        send_byte(8'h4D);
        for (int i = 0; i < 2000 && got_q.size() < 9; i++) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_reset_nbytes", got_q.size(), 9);
        for (int i = 0; i < 9 && i < got_q.size(); i++)
            check($sformatf("mid_reset_byte%0d", i), got_q[i], exp_q[i]);
        pc = $urandom;
        run_p("P_after_reset");

        // Randomized command mix.
        for (int it = 0; it < 12; it++) begin
            sel = $urandom_range(0, 3);
            pc  = $urandom;
            case (sel)
                0: run_p($sformatf("rnd%0d_P", it));
                1: run_s($sformatf("rnd%0d_S", it), 1'($urandom_range(0, 1)));
                2: run_c($sformatf("rnd%0d_C", it), $urandom_range(1, 12),
                         1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
                default: run_m($sformatf("rnd%0d_M", it));
            endcase
        end
        check("tx_data_stable_end", unstable, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
